// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle MIPS-style datapath
// Ports:
//   clk, rst (sync, active-low)           clock and reset
//   run                                   1 = execute, 0 = park in IDLE at next instruction boundary
//   op, func                              opcode/function fields of the instruction register
//   zf, mem_ack                           ALU zero flag, memory completion
//   pc_we, ir_we, reg_we, pc_src          PC / IR / register-file enables, PC source select
//   reg_dst, alu_src_b, mem_to_reg        datapath muxes
//   alu_op                                ALU operation code
//   mem_req, mem_we, i_or_d               memory request, write strobe, address select
//   state, trap, retired                  current state, trap flag, retired-instruction count
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zf,
  input  logic        mem_ack,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        pc_src,
  output logic        reg_dst,
  output logic        alu_src_b,
  output logic        mem_to_reg,
  output logic [2:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic [2:0]  state,
  output logic        trap,
  output logic [15:0] retired
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd7
  } st_t;
  st_t st, st_nxt, boundary;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic ok, retire, timeout, in_instr;
  logic is_r, is_lw, is_sw, is_beq;
  logic [2:0] code;
  assign is_r   = op == 6'h00;
  assign is_lw  = op == 6'h23;
  assign is_sw  = op == 6'h2B;
  assign is_beq = op == 6'h04;
  // code stays 0 for unsupported encodings, so alu_op is 0 on the way to TRAP
  always_comb begin
    ok = 1'b1;
    code = 3'd0;
    if (is_r)
      case (func)
        6'h24: code = 3'd0;
        6'h25: code = 3'd1;
        6'h26: code = 3'd2;
        6'h27: code = 3'd3;
        6'h20: code = 3'd4;
        6'h22: code = 3'd5;
        6'h2B: code = 3'd6;
        6'h04: code = 3'd7;
        default: ok = 1'b0;
      endcase
    else
      case (op)
        6'h08, 6'h23, 6'h2B: code = 3'd4;
        6'h0C: code = 3'd0;
        6'h0D: code = 3'd1;
        6'h0E: code = 3'd2;
        6'h04: code = 3'd5;
        default: ok = 1'b0;
      endcase
  end
  // the ack-less cycle that brings the count to MEM_TIMEOUT is the last one allowed
  assign timeout   = wait_cnt == CW'(MEM_TIMEOUT - 1);
  assign boundary  = run ? FETCH : IDLE;
  assign in_instr  = st inside {DECODE, EXEC, MEM, WB};
  assign alu_op    = in_instr ? code : 3'd0;
  assign alu_src_b = in_instr && ok && !is_r && !is_beq;
  assign state     = st;
  assign trap      = st == TRAP;
  always_comb begin
    st_nxt = st;
    pc_we = 1'b0;
    ir_we = 1'b0;
    reg_we = 1'b0;
    pc_src = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    i_or_d = 1'b0;
    retire = 1'b0;
    case (st)
      IDLE: st_nxt = run ? FETCH : IDLE;
      FETCH: begin
        mem_req = 1'b1;
        ir_we = mem_ack;
        pc_we = mem_ack;
        st_nxt = mem_ack ? DECODE : timeout ? TRAP : FETCH;
      end
      DECODE: st_nxt = ok ? EXEC : TRAP;
      EXEC: begin
        pc_we = is_beq & zf;
        pc_src = is_beq;
        retire = is_beq;
        st_nxt = is_beq ? boundary : (is_lw | is_sw) ? MEM : WB;
      end
      MEM: begin
        mem_req = 1'b1;
        i_or_d = 1'b1;
        mem_we = is_sw;
        retire = mem_ack & is_sw;
        st_nxt = mem_ack ? (is_sw ? boundary : WB) : timeout ? TRAP : MEM;
      end
      WB: begin
        reg_we = 1'b1;
        reg_dst = is_r;
        mem_to_reg = is_lw;
        retire = 1'b1;
        st_nxt = boundary;
      end
      TRAP: st_nxt = TRAP;
      default: st_nxt = IDLE;
    endcase
  end
  // counting only while staying in FETCH/MEM means every entry starts from zero
  assign wait_nxt = (st_nxt == st && (st == FETCH || st == MEM)) ? wait_cnt + CW'(1) : '0;
  always_ff @(posedge clk)
    if (!rst) begin
      st <= IDLE;
      wait_cnt <= '0;
      retired <= '0;
    end else begin
      st <= st_nxt;
      wait_cnt <= wait_nxt;
      retired <= retired + 16'(retire);
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; instruction-level model pushes per-cycle expectations, negedge monitor compares
module tb_multicycle_ctrl;
  localparam int T = 15;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0, zf = 1'b0, mem_ack = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic pc_we, ir_we, reg_we, pc_src, reg_dst, alu_src_b, mem_to_reg, mem_req, mem_we, i_or_d, trap;
  logic [2:0] alu_op, state;
  logic [15:0] retired;
  typedef struct packed {
    logic [2:0]  st;
    logic        pc_we, ir_we, reg_we, pc_src, reg_dst, alu_src_b, mem_to_reg;
    logic [2:0]  alu_op;
    logic        mem_req, mem_we, i_or_d, trap;
    logic [15:0] retired;
  } obs_t;
  obs_t exp_q[$];
  obs_t dut_obs, mon_e;
  int n_chk = 0, n_fail = 0;
  int unsigned m_ret = 0;
  bit at_idle = 1'b1;
  int r_alu[int];
  int i_alu[int];
  logic [11:0] ins_tab [0:15] = '{
    {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h26}, {6'h00, 6'h27},
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2B}, {6'h00, 6'h04},
    {6'h08, 6'h00}, {6'h0C, 6'h00}, {6'h0D, 6'h00}, {6'h0E, 6'h00},
    {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h3F, 6'h00}
  };
  always #5 clk = ~clk;
  multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op), .func(func), .zf(zf), .mem_ack(mem_ack),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .pc_src(pc_src), .reg_dst(reg_dst),
    .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .mem_req(mem_req),
    .mem_we(mem_we), .i_or_d(i_or_d), .state(state), .trap(trap), .retired(retired)
  );
  assign dut_obs = {state, pc_we, ir_we, reg_we, pc_src, reg_dst, alu_src_b, mem_to_reg,
                    alu_op, mem_req, mem_we, i_or_d, trap, retired};
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_chk++;
      if (dut_obs !== mon_e) begin
        n_fail++;
        $display("FAIL cycle_obs t=%0t actual state=%0d obs=%h required state=%0d obs=%h",
                 $time, dut_obs.st, dut_obs, mon_e.st, mon_e);
      end
    end
  function automatic obs_t mk(input logic [2:0] s);
    obs_t e;
    e = '0;
    e.st = s;
    e.trap = s == 3'd7;
    e.retired = m_ret[15:0];
    return e;
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    return r == 0 ? T : r == 1 ? T - 1 : $urandom_range(0, 3);
  endfunction
  task automatic tick(input obs_t e, input logic ack);
    mem_ack = ack;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    mem_ack = rb();
    run = rb();
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_ret = 0;
    at_idle = 1'b1;
  endtask
  task automatic trap_reset(input int n);
    for (int i = 0; i < n; i++) begin
      run = rb();
      tick(mk(3'd7), rb());
    end
    do_reset();
  endtask
  task automatic enter(input int idle_cycles);
    if (at_idle) begin
      run = 1'b0;
      for (int i = 0; i < idle_cycles; i++) tick(mk(3'd0), rb());
      run = 1'b1;
      tick(mk(3'd0), rb());
      at_idle = 1'b0;
    end
  endtask
  task automatic access(input obs_t base, input obs_t on_ack, input int w, output bit acked);
    acked = 1'b0;
    for (int k = 0; k < T && !acked; k++)
      if (k == w) begin
        acked = 1'b1;
        tick(on_ack, 1'b1);
      end else tick(base, 1'b0);
  endtask
  task automatic classify(input logic [5:0] o, input logic [5:0] f, output bit ok,
                          output logic [2:0] code, output int kind);
    ok = 1'b0;
    code = 3'd0;
    kind = K_R;
    if (o == 6'h00) begin
      if (r_alu.exists(int'(f))) begin
        ok = 1'b1;
        code = 3'(r_alu[int'(f)]);
      end
    end else if (i_alu.exists(int'(o))) begin
      ok = 1'b1;
      code = 3'(i_alu[int'(o)]);
      kind = o == 6'h23 ? K_LW : o == 6'h2B ? K_SW : o == 6'h04 ? K_BEQ : K_I;
    end
  endtask
  task automatic boundary(input logic run_end);
    m_ret++;
    at_idle = !run_end;
  endtask
  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int fw, input int mw, input logic run_end);
    bit ok, acked;
    logic [2:0] code;
    int kind;
    obs_t e, a;
    classify(o, f, ok, code, kind);
    enter($urandom_range(0, 2));
    op = o;
    func = f;
    e = mk(3'd1);
    e.mem_req = 1'b1;
    a = e;
    a.ir_we = 1'b1;
    a.pc_we = 1'b1;
    access(e, a, fw, acked);
    if (!acked) begin
      trap_reset(3);
      return;
    end
    run = run_end;
    e = mk(3'd2);
    if (ok) begin
      e.alu_op = code;
      e.alu_src_b = kind != K_R && kind != K_BEQ;
    end
    zf = rb();
    tick(e, rb());
    if (!ok) begin
      trap_reset(2);
      return;
    end
    e.st = 3'd3;
    if (kind == K_BEQ) begin
      zf = z;
      e.pc_we = z;
      e.pc_src = 1'b1;
      tick(e, rb());
      boundary(run_end);
      return;
    end
    zf = rb();
    tick(e, rb());
    if (kind == K_LW || kind == K_SW) begin
      e.st = 3'd4;
      e.mem_req = 1'b1;
      e.i_or_d = 1'b1;
      e.mem_we = kind == K_SW;
      access(e, e, mw, acked);
      if (!acked) begin
        trap_reset(3);
        return;
      end
      if (kind == K_SW) begin
        boundary(run_end);
        return;
      end
      e.mem_req = 1'b0;
      e.i_or_d = 1'b0;
      e.mem_we = 1'b0;
    end
    e.st = 3'd5;
    e.reg_we = 1'b1;
    e.reg_dst = kind == K_R;
    e.mem_to_reg = kind == K_LW;
    tick(e, rb());
    boundary(run_end);
  endtask
  task automatic fetch_abort(input int n);
    obs_t e;
    enter(0);
    op = 6'h00;
    func = 6'h20;
    e = mk(3'd1);
    e.mem_req = 1'b1;
    for (int i = 0; i < n; i++) tick(e, 1'b0);
    do_reset();
  endtask
  initial begin
    r_alu[6'h24] = 0; r_alu[6'h25] = 1; r_alu[6'h26] = 2; r_alu[6'h27] = 3;
    r_alu[6'h20] = 4; r_alu[6'h22] = 5; r_alu[6'h2B] = 6; r_alu[6'h04] = 7;
    i_alu[6'h08] = 4; i_alu[6'h0C] = 0; i_alu[6'h0D] = 1; i_alu[6'h0E] = 2;
    i_alu[6'h23] = 4; i_alu[6'h2B] = 4; i_alu[6'h04] = 5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    instr(6'h00, 6'h20, 1'b0, 2, 0, 1'b1);
    instr(6'h23, 6'h00, 1'b0, 0, 0, 1'b1);
    instr(6'h2B, 6'h00, 1'b0, 0, 0, 1'b1);
    instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b1);
    instr(6'h04, 6'h00, 1'b0, 1, 0, 1'b1);
    instr(6'h23, 6'h00, 1'b0, 0, 2, 1'b0);
    instr(6'h0D, 6'h00, 1'b0, T - 1, 0, 1'b1);
    instr(6'h00, 6'h20, 1'b0, T, 0, 1'b1);
    instr(6'h00, 6'h22, 1'b0, 0, 0, 1'b1);
    instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b1);
    instr(6'h00, 6'h3F, 1'b0, 0, 0, 1'b1);
    instr(6'h2B, 6'h00, 1'b0, 1, T - 1, 1'b1);
    instr(6'h23, 6'h00, 1'b0, 0, T, 1'b1);
    fetch_abort(2);
    for (int i = 0; i < 80; i++) begin
      logic [11:0] w;
      w = ins_tab[$urandom_range(0, 15)];
      instr(w[11:6], w[5:0], rb(), pick_wait(), pick_wait(), $urandom_range(0, 3) != 0);
    end
    enter(1);
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
